// File: rtl/pc_seq_pkg.sv
// Shared types and opcode constants for the PC fetch sequencer.
package pc_seq_pkg;

   localparam int unsigned OP_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_UPDATE,
      ST_HALTED
   } state_e;

   typedef enum logic {
      ACT_INC,
      ACT_LOAD
   } action_e;

   localparam logic [OP_W-1:0] OP_JMP  = 4'hC;
   localparam logic [OP_W-1:0] OP_BZ   = 4'hD;
   localparam logic [OP_W-1:0] OP_HALT = 4'hF;

endpackage

// File: rtl/pc_seq_decode.sv
// Opcode decode: picks increment vs load for the counter and flags HALT.
module pc_seq_decode
   import pc_seq_pkg::*;
(
   input  logic [OP_W-1:0] opcode,
   input  logic            zero_flag,
   output action_e         action,
   output logic            is_halt
);

   always_comb begin
      action  = ACT_INC;
      is_halt = 1'b0;
      case (opcode)
         OP_JMP:  action = ACT_LOAD;
         OP_BZ:   action = zero_flag ? ACT_LOAD : ACT_INC;
         OP_HALT: is_halt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: fetch at PC, issue to execute, then one IPC or LPC pulse back to the counter.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned n = 8,
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         clear_n,
   input  logic [n-1:0] pc_value,
   output logic         IPC,
   output logic         LPC,
   output logic [n-1:0] pc_input,
   output logic [n-1:0] imem_addr,
   output logic         imem_req,
   input  logic         imem_ack,
   input  logic [W-1:0] imem_data,
   output logic [W-1:0] instr,
   output logic         instr_valid,
   input  logic         instr_ready,
   input  logic         zero_flag,
   input  logic         resume,
   output logic         halted
);

   state_e         state, state_nxt;
   logic           ipc_nxt, lpc_nxt;
   logic [n-1:0]   pc_input_nxt;
   logic [W-1:0]   instr_nxt;
   logic           valid_nxt;
   logic           halt_pend, halt_pend_nxt;
   action_e        dec_action;
   logic           dec_is_halt;

   pc_seq_decode u_decode (
      .opcode    (instr[W-1:W-OP_W]),
      .zero_flag (zero_flag),
      .action    (dec_action),
      .is_halt   (dec_is_halt)
   );

   // Next state, registered-output next values, and state-decoded fetch/halt outputs
   always_comb begin
      state_nxt     = state;
      ipc_nxt       = 1'b0;
      lpc_nxt       = 1'b0;
      pc_input_nxt  = pc_input;
      instr_nxt     = instr;
      valid_nxt     = instr_valid;
      halt_pend_nxt = halt_pend;
      imem_req      = 1'b0;
      imem_addr     = '0;
      halted        = 1'b0;
      case (state)
         ST_IDLE: state_nxt = ST_FETCH;
         ST_FETCH: begin
            imem_req  = 1'b1;
            imem_addr = pc_value;
            if (imem_ack) begin
               instr_nxt = imem_data;
               valid_nxt = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (instr_ready) begin
               valid_nxt     = 1'b0;
               halt_pend_nxt = dec_is_halt;
               if (dec_action == ACT_LOAD) begin
                  lpc_nxt      = 1'b1;
                  pc_input_nxt = instr[n-1:0];
               end else begin
                  ipc_nxt = 1'b1;
               end
               state_nxt = ST_UPDATE;
            end
         end
         ST_UPDATE: state_nxt = halt_pend ? ST_HALTED : ST_FETCH;
         ST_HALTED: begin
            halted = 1'b1;
            if (resume) state_nxt = ST_FETCH;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state       <= ST_IDLE;
         IPC         <= 1'b0;
         LPC         <= 1'b0;
         pc_input    <= '0;
         instr       <= '0;
         instr_valid <= 1'b0;
         halt_pend   <= 1'b0;
      end else begin
         state       <= state_nxt;
         IPC         <= ipc_nxt;
         LPC         <= lpc_nxt;
         pc_input    <= pc_input_nxt;
         instr       <= instr_nxt;
         instr_valid <= valid_nxt;
         halt_pend   <= halt_pend_nxt;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a small PC counter model on the control side.
module tb_pc_sequencer;

   localparam int unsigned N = 8;
   localparam int unsigned WI = 16;

   logic          clk;
   logic          clear_n;
   logic [N-1:0]  pc_value;
   logic          IPC, LPC;
   logic [N-1:0]  pc_input;
   logic [N-1:0]  imem_addr;
   logic          imem_req;
   logic          imem_ack;
   logic [WI-1:0] imem_data;
   logic [WI-1:0] instr;
   logic          instr_valid;
   logic          instr_ready;
   logic          zero_flag;
   logic          resume;
   logic          halted;

   int checks = 0;
   int errors = 0;

   pc_sequencer #(.n(N), .W(WI)) dut (
      .clk         (clk),
      .clear_n     (clear_n),
      .pc_value    (pc_value),
      .IPC         (IPC),
      .LPC         (LPC),
      .pc_input    (pc_input),
      .imem_addr   (imem_addr),
      .imem_req    (imem_req),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .zero_flag   (zero_flag),
      .resume      (resume),
      .halted      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program counter the sequencer controls
   always @(posedge clk or negedge clear_n) begin
      if (!clear_n)  pc_value <= '0;
      else if (LPC)  pc_value <= pc_input;
      else if (IPC)  pc_value <= pc_value + 8'd1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".ipc"},   32'(IPC), 32'd0);
      check({tag, ".lpc"},   32'(LPC), 32'd0);
      check({tag, ".pcin"},  32'(pc_input), 32'd0);
      check({tag, ".req"},   32'(imem_req), 32'd0);
      check({tag, ".addr"},  32'(imem_addr), 32'd0);
      check({tag, ".instr"}, 32'(instr), 32'd0);
      check({tag, ".valid"}, 32'(instr_valid), 32'd0);
      check({tag, ".halt"},  32'(halted), 32'd0);
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      clear_n     = 1'b0;
      imem_ack    = 1'b1;
      imem_data   = 16'h1234;
      instr_ready = 1'b1;
      zero_flag   = 1'b0;
      resume      = 1'b0;
      cyc(); cyc();
      check_zero("reset");
      clear_n = 1'b1;
      #1 check("idle.req", 32'(imem_req), 32'd0);

      // plain increment
      cyc();
      check("f0.req",  32'(imem_req), 32'd1);
      check("f0.addr", 32'(imem_addr), 32'h00);
      check("f0.valid", 32'(instr_valid), 32'd0);
      cyc();
      check("i0.valid", 32'(instr_valid), 32'd1);
      check("i0.instr", 32'(instr), 32'h1234);
      check("i0.req",   32'(imem_req), 32'd0);
      cyc();
      check("u0.ipc",   32'(IPC), 32'd1);
      check("u0.lpc",   32'(LPC), 32'd0);
      check("u0.valid", 32'(instr_valid), 32'd0);
      imem_data = 16'hC0A5;
      cyc();
      check("f1.addr", 32'(imem_addr), 32'h01);
      check("f1.ipc",  32'(IPC), 32'd0);

      // JMP
      cyc();
      check("jmp.instr", 32'(instr), 32'hC0A5);
      cyc();
      check("jmp.lpc",  32'(LPC), 32'd1);
      check("jmp.ipc",  32'(IPC), 32'd0);
      check("jmp.pcin", 32'(pc_input), 32'hA5);
      imem_data = 16'hD010;
      zero_flag = 1'b1;
      cyc();
      check("jmp.addr", 32'(imem_addr), 32'hA5);

      // BZ taken, then not taken
      cyc();
      cyc();
      check("bz1.lpc",  32'(LPC), 32'd1);
      check("bz1.ipc",  32'(IPC), 32'd0);
      check("bz1.pcin", 32'(pc_input), 32'h10);
      zero_flag = 1'b0;
      cyc();
      check("bz1.addr", 32'(imem_addr), 32'h10);
      cyc();
      cyc();
      check("bz0.ipc", 32'(IPC), 32'd1);
      check("bz0.lpc", 32'(LPC), 32'd0);
      imem_data = 16'hC007;
      cyc();
      check("bz0.addr", 32'(imem_addr), 32'h11);

      // JMP to 07, then HALT there
      cyc();
      cyc();
      check("j7.pcin", 32'(pc_input), 32'h07);
      imem_data = 16'hF000;
      cyc();
      check("h.addr", 32'(imem_addr), 32'h07);
      cyc();
      cyc();
      check("h.ipc", 32'(IPC), 32'd1);
      check("h.lpc", 32'(LPC), 32'd0);
      for (int i = 0; i < 10; i++) begin
         cyc();
         check("h.halted", 32'(halted), 32'd1);
         check("h.req",    32'(imem_req), 32'd0);
         check("h.ipc_lo", 32'(IPC), 32'd0);
      end
      check("h.pc", 32'(pc_value), 32'h08);
      resume    = 1'b1;
      imem_ack  = 1'b0;
      instr_ready = 1'b0;
      imem_data = 16'h1234;

      // resume, then ack delayed 3 cycles and ready delayed 2 cycles
      for (int i = 0; i < 4; i++) begin
         cyc();
         resume = 1'b0;
         check("d.req",   32'(imem_req), 32'd1);
         check("d.addr",  32'(imem_addr), 32'h08);
         check("d.halt",  32'(halted), 32'd0);
         check("d.valid", 32'(instr_valid), 32'd0);
         if (i == 3) imem_ack = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
         cyc();
         imem_data = 16'hFFFF;
         imem_ack  = 1'b0;
         resume    = 1'b1;
         check("w.valid", 32'(instr_valid), 32'd1);
         check("w.instr", 32'(instr), 32'h1234);
         check("w.ipc",   32'(IPC), 32'd0);
         check("w.halt",  32'(halted), 32'd0);
         if (i == 2) instr_ready = 1'b1;
      end
      cyc();
      resume = 1'b0;
      check("w.ipc1",  32'(IPC), 32'd1);
      check("w.lpc1",  32'(LPC), 32'd0);
      cyc();
      check("w.ipc2",  32'(IPC), 32'd0);
      check("w.addr",  32'(imem_addr), 32'h09);
      check("w.halt2", 32'(halted), 32'd0);

      // reset mid-fetch
      #2 clear_n = 1'b0;
      #1 check_zero("rst_f");
      cyc();
      check_zero("rst_f_hold");
      imem_ack  = 1'b1;
      imem_data = 16'h1234;
      clear_n   = 1'b1;
      #1 check("rst_f.idle", 32'(imem_req), 32'd0);
      cyc();
      check("rst_f.req",  32'(imem_req), 32'd1);
      check("rst_f.addr", 32'(imem_addr), 32'h00);
      cyc();
      cyc();
      check("rst_u.ipc_pre", 32'(IPC), 32'd1);

      // reset during UPDATE
      #2 clear_n = 1'b0;
      #1 check_zero("rst_u");
      cyc();
      check_zero("rst_u_hold");
      clear_n = 1'b1;
      #1 check("rst_u.idle", 32'(imem_req), 32'd0);
      check("rst_u.ipc_idle", 32'(IPC), 32'd0);
      cyc();
      check("rst_u.req",  32'(imem_req), 32'd1);
      check("rst_u.addr", 32'(imem_addr), 32'h00);
      check("rst_u.ipc",  32'(IPC), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
